dmem_lane_ctrl: RTL and testbench

//  Data-memory access controller sitting between the load/store stage and the four

---
 rtl/dmem_lane_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_dmem_lane_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_lane_ctrl.sv
// Data-memory lane controller: splits one load/store into four byte-lane bank accesses,
// assembles and extends load data, and rejects out-of-range, illegal or disallowed requests.
`timescale 1ns/1ps
module dmem_lane_ctrl #(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter bit          ALLOW_MISALIGN = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic [55:0] bank_addr_o,
  output logic [3:0]  bank_wren_o,
  output logic [31:0] bank_wdata_o,
  input  logic [31:0] bank_rdata_i
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  state_t      state_q, state_d;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;
  logic        err_q;
  logic [3:0]  lane_en_q;
  logic [55:0] bank_addr_q, bank_addr_d;
  logic [31:0] bank_wdata_q, bank_wdata_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q;

  logic [31:0] rel_addr;
  logic [1:0]  off;
  logic [13:0] word_idx;
  logic [3:0]  size_mask;
  logic [1:0]  size_m1;
  logic [7:0]  mask_rot;
  logic [3:0]  lane_en;
  logic [32:0] last_byte;
  logic        range_err, funct3_err, misalign_err, req_err;
  logic        capture, finish;
  logic [31:0] load_raw;

  function automatic logic [31:0] load_ext(input logic [31:0] raw, input logic [2:0] f3);
    case (f3)
      3'b000:  load_ext = {{24{raw[7]}}, raw[7:0]};
      3'b001:  load_ext = {{16{raw[15]}}, raw[15:0]};
      3'b100:  load_ext = {24'h0, raw[7:0]};
      3'b101:  load_ext = {16'h0, raw[15:0]};
      default: load_ext = raw;
    endcase
  endfunction

  assign rel_addr = req_addr_i - BASE_ADDR;
  assign off      = rel_addr[1:0];
  assign word_idx = rel_addr[15:2];

  always_comb begin
    case (req_funct3_i[1:0])
      2'b00:   begin size_mask = 4'b0001; size_m1 = 2'd0; end
      2'b01:   begin size_mask = 4'b0011; size_m1 = 2'd1; end
      default: begin size_mask = 4'b1111; size_m1 = 2'd3; end
    endcase
  end

  // The enable mask is the size mask rotated left by the byte offset.
  assign mask_rot  = {size_mask, size_mask} << off;
  assign lane_en   = mask_rot[7:4];
  // 33-bit sum so a request near 2^32 cannot wrap back into range.
  assign last_byte = {1'b0, rel_addr} + 33'(size_m1);
  assign range_err = last_byte > 33'h0_0000_FFFF;

  always_comb begin
    case (req_funct3_i)
      3'b000, 3'b001, 3'b010: funct3_err = 1'b0;
      3'b100, 3'b101:         funct3_err = req_we_i;
      default:                funct3_err = 1'b1;
    endcase
  end

  assign misalign_err = !ALLOW_MISALIGN &&
                        (((req_funct3_i[1:0] == 2'b01) && off[0]) ||
                         ((req_funct3_i[1:0] == 2'b10) && (off != 2'b00)));
  assign req_err = range_err | funct3_err | misalign_err;

  always_comb begin
    bank_addr_d  = '0;
    bank_wdata_d = '0;
    for (int k = 0; k < 4; k++) begin
      logic [1:0] byte_sel;
      byte_sel = 2'(k) - off;
      // Lanes below the offset hold the bytes that spilled into the next word.
      bank_addr_d[14*k +: 14] = word_idx + ((2'(k) < off) ? 14'd1 : 14'd0);
      if (lane_en[k] && req_we_i && !req_err)
        bank_wdata_d[8*k +: 8] = req_wdata_i[8*byte_sel +: 8];
    end
  end

  always_comb begin
    load_raw = '0;
    for (int i = 0; i < 4; i++) begin
      logic [1:0] lane;
      lane = off_q + 2'(i);
      load_raw[8*i +: 8] = bank_rdata_i[8*lane +: 8];
    end
  end

  assign rsp_rdata_d = (!we_q && !err_q) ? load_ext(load_raw, funct3_q) : 32'h0;

  always_comb begin
    state_d     = state_q;
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    bank_wren_o = 4'b0000;
    capture     = 1'b0;
    finish      = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          capture = 1'b1;
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (we_q && !err_q) bank_wren_o = lane_en_q;
        finish  = 1'b1;
        state_d = S_RESP;
      end
      S_RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      we_q         <= 1'b0;
      funct3_q     <= 3'b000;
      off_q        <= 2'b00;
      err_q        <= 1'b0;
      lane_en_q    <= 4'b0000;
      bank_addr_q  <= '0;
      bank_wdata_q <= '0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        we_q         <= req_we_i;
        funct3_q     <= req_funct3_i;
        off_q        <= off;
        err_q        <= req_err;
        lane_en_q    <= lane_en;
        bank_addr_q  <= bank_addr_d;
        bank_wdata_q <= bank_wdata_d;
      end
      if (finish) begin
        rsp_rdata_q <= rsp_rdata_d;
        rsp_err_q   <= err_q;
      end
    end
  end

  assign bank_addr_o  = bank_addr_q;
  assign bank_wdata_o = bank_wdata_q;
  assign rsp_rdata_o  = rsp_rdata_q;
  assign rsp_err_o    = rsp_err_q;

endmodule

// File: tb/tb_dmem_lane_ctrl.sv
// Directed bench for dmem_lane_ctrl: a byte-lane bank model behind the default instance,
// plus a second instance with misaligned access disabled.
`timescale 1ns/1ps
module tb_dmem_lane_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        req_valid0 = 0, req_we0 = 0, rsp_ready0 = 1;
  logic [2:0]  req_f30 = 0;
  logic [31:0] req_addr0 = 0, req_wdata0 = 0;
  logic        req_ready0, rsp_valid0, rsp_err0;
  logic [31:0] rsp_rdata0, bank_wdata0, bank_rdata0;
  logic [55:0] bank_addr0;
  logic [3:0]  bank_wren0;

  logic        req_valid1 = 0, req_we1 = 0;
  logic [2:0]  req_f31 = 0;
  logic [31:0] req_addr1 = 0, req_wdata1 = 0;
  logic        req_ready1, rsp_valid1, rsp_err1;
  logic [31:0] rsp_rdata1, bank_wdata1;
  logic [31:0] bank_rdata1 = 32'h0;
  logic [55:0] bank_addr1;
  logic [3:0]  bank_wren1;

  int total = 0;
  int bad   = 0;
  int wren_cnt0 = 0;
  int wren_cnt1 = 0;

  dmem_lane_ctrl dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid0), .req_ready_o(req_ready0), .req_we_i(req_we0),
    .req_funct3_i(req_f30), .req_addr_i(req_addr0), .req_wdata_i(req_wdata0),
    .rsp_valid_o(rsp_valid0), .rsp_ready_i(rsp_ready0), .rsp_rdata_o(rsp_rdata0),
    .rsp_err_o(rsp_err0), .bank_addr_o(bank_addr0), .bank_wren_o(bank_wren0),
    .bank_wdata_o(bank_wdata0), .bank_rdata_i(bank_rdata0)
  );

  dmem_lane_ctrl #(.BASE_ADDR(32'h0), .ALLOW_MISALIGN(1'b0)) dut_strict (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid1), .req_ready_o(req_ready1), .req_we_i(req_we1),
    .req_funct3_i(req_f31), .req_addr_i(req_addr1), .req_wdata_i(req_wdata1),
    .rsp_valid_o(rsp_valid1), .rsp_ready_i(1'b1), .rsp_rdata_o(rsp_rdata1),
    .rsp_err_o(rsp_err1), .bank_addr_o(bank_addr1), .bank_wren_o(bank_wren1),
    .bank_wdata_o(bank_wdata1), .bank_rdata_i(bank_rdata1)
  );

  // Four byte-wide 16k-deep banks, async read, write on rising edge.
  logic [7:0] mem [4][16384];
  for (genvar g = 0; g < 4; g++) begin : g_rd
    assign bank_rdata0[8*g +: 8] = mem[g][bank_addr0[14*g +: 14]];
  end
  always @(posedge clk) begin
    for (int k = 0; k < 4; k++)
      if (bank_wren0[k]) mem[k][bank_addr0[14*k +: 14]] <= bank_wdata0[8*k +: 8];
  end

  always @(negedge clk) begin
    if (bank_wren0 != 4'b0) wren_cnt0 <= wren_cnt0 + 1;
    if (bank_wren1 != 4'b0) wren_cnt1 <= wren_cnt1 + 1;
  end

  // One transaction on the default instance; also returns what the banks saw in ACCESS.
  task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wd, output logic [31:0] rd, output logic er,
                      output int lat, output logic [55:0] acc_addr,
                      output logic [3:0] acc_wren, output logic [31:0] acc_wdata);
    @(negedge clk);
    req_valid0 = 1; req_we0 = we; req_f30 = f3; req_addr0 = addr; req_wdata0 = wd;
    @(posedge clk); #1;
    req_valid0 = 0;
    acc_addr = bank_addr0; acc_wren = bank_wren0; acc_wdata = bank_wdata0;
    lat = 0;
    while (!rsp_valid0 && lat < 10) begin
      @(posedge clk); #1; lat++;
    end
    rd = rsp_rdata0; er = rsp_err0;
    if (lat >= 10) begin
      total++; bad++;
      $display("FAIL timeout addr=%h no rsp_valid within 10 cycles", addr);
    end
    @(posedge clk); #1;
  endtask

  task automatic xact_strict(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                             output logic er, output logic [3:0] acc_wren);
    int n;
    @(negedge clk);
    req_valid1 = 1; req_we1 = we; req_f31 = f3; req_addr1 = addr; req_wdata1 = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    req_valid1 = 0;
    acc_wren = bank_wren1;
    n = 0;
    while (!rsp_valid1 && n < 10) begin
      @(posedge clk); #1; n++;
    end
    er = rsp_err1;
    if (n >= 10) begin
      total++; bad++;
      $display("FAIL strict_timeout addr=%h", addr);
    end
    @(posedge clk); #1;
  endtask

  logic [31:0] rd, awd;
  logic        er;
  int          lat;
  logic [55:0] aad;
  logic [3:0]  awr;

  task automatic test_reset();
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({req_ready0, rsp_valid0, rsp_err0} !== 3'b100) begin
      bad++; $display("FAIL reset_ctrl got=%b exp=100", {req_ready0, rsp_valid0, rsp_err0});
    end
    total++;
    if ({rsp_rdata0, bank_wdata0, bank_wren0} !== 68'h0) begin
      bad++; $display("FAIL reset_data rdata=%h wdata=%h wren=%b exp=0", rsp_rdata0, bank_wdata0, bank_wren0);
    end
    total++;
    if (bank_addr0 !== 56'h0) begin
      bad++; $display("FAIL reset_addr got=%h exp=0", bank_addr0);
    end
    @(negedge clk); rst = 0;
  endtask

  task automatic test_word();
    xact(1, 3'b010, 32'h10, 32'h1122_3344, rd, er, lat, aad, awr, awd);
    total++;
    if (er !== 1'b0 || lat !== 1) begin
      bad++; $display("FAIL sw_word err=%b lat=%0d exp err=0 lat=1", er, lat);
    end
    total++;
    if (aad !== {14'd4, 14'd4, 14'd4, 14'd4} || awr !== 4'hF || awd !== 32'h1122_3344) begin
      bad++; $display("FAIL sw_word_lanes addr=%h wren=%b wdata=%h", aad, awr, awd);
    end
    xact(0, 3'b010, 32'h10, 32'h0, rd, er, lat, aad, awr, awd);
    total++;
    if (rd !== 32'h1122_3344 || er !== 1'b0 || lat !== 1) begin
      bad++; $display("FAIL lw_word got=%h err=%b lat=%0d exp=11223344 err=0 lat=1", rd, er, lat);
    end
    total++;
    if (awr !== 4'h0) begin
      bad++; $display("FAIL lw_no_wren got=%b exp=0000", awr);
    end
  endtask

  task automatic test_byte();
    xact(1, 3'b000, 32'h13, 32'hFFFF_FF80, rd, er, lat, aad, awr, awd);
    total++;
    if (awr !== 4'b1000 || awd !== 32'h8000_0000 || aad !== {14'd4, 14'd5, 14'd5, 14'd5}) begin
      bad++; $display("FAIL sb_lanes wren=%b wdata=%h addr=%h exp 1000/80000000", awr, awd, aad);
    end
    xact(0, 3'b000, 32'h13, 32'h0, rd, er, lat, aad, awr, awd);
    total++;
    if (rd !== 32'hFFFF_FF80) begin
      bad++; $display("FAIL lb_sign got=%h exp=ffffff80", rd);
    end
    xact(0, 3'b100, 32'h13, 32'h0, rd, er, lat, aad, awr, awd);
    total++;
    if (rd !== 32'h0000_0080) begin
      bad++; $display("FAIL lbu_zero got=%h exp=00000080", rd);
    end
    xact(0, 3'b010, 32'h10, 32'h0, rd, er, lat, aad, awr, awd);
    total++;
    if (rd !== 32'h8022_3344) begin
      bad++; $display("FAIL sb_untouched got=%h exp=80223344", rd);
    end
  endtask

  task automatic test_misalign();
    int w1;
    xact(1, 3'b010, 32'h0E, 32'hAABB_CCDD, rd, er, lat, aad, awr, awd);
    total++;
    if (aad !== {14'd3, 14'd3, 14'd4, 14'd4} || awr !== 4'hF || er !== 1'b0) begin
      bad++; $display("FAIL sw_mis_lanes addr=%h wren=%b err=%b", aad, awr, er);
    end
    total++;
    if (awd !== 32'hCCDD_AABB) begin
      bad++; $display("FAIL sw_mis_wdata got=%h exp=ccddaabb", awd);
    end
    xact(0, 3'b010, 32'h0E, 32'h0, rd, er, lat, aad, awr, awd);
    total++;
    if (rd !== 32'hAABB_CCDD || er !== 1'b0) begin
      bad++; $display("FAIL lw_mis got=%h err=%b exp=aabbccdd", rd, er);
    end
    xact(0, 3'b001, 32'h0F, 32'h0, rd, er, lat, aad, awr, awd);
    total++;
    if (rd !== 32'hFFFF_BBCC) begin
      bad++; $display("FAIL lh_wrap got=%h exp=ffffbbcc", rd);
    end
    w1 = wren_cnt1;
    xact_strict(1, 3'b010, 32'h0E, er, awr);
    total++;
    if (er !== 1'b1 || awr !== 4'h0 || wren_cnt1 != w1) begin
      bad++; $display("FAIL strict_sw_mis err=%b wren=%b pulses=%0d exp err=1 none", er, awr, wren_cnt1 - w1);
    end
    xact_strict(0, 3'b001, 32'h0F, er, awr);
    total++;
    if (er !== 1'b1) begin
      bad++; $display("FAIL strict_lh_mis err=%b exp=1", er);
    end
    xact_strict(0, 3'b010, 32'h10, er, awr);
    total++;
    if (er !== 1'b0) begin
      bad++; $display("FAIL strict_lw_aligned err=%b exp=0", er);
    end
  endtask

  task automatic test_range();
    int w0;
    xact(1, 3'b000, 32'hFFFF, 32'h0000_005A, rd, er, lat, aad, awr, awd);
    total++;
    if (er !== 1'b0 || awr !== 4'b1000 || aad[55:42] !== 14'h3FFF) begin
      bad++; $display("FAIL sb_top err=%b wren=%b idx=%h exp 0/1000/3fff", er, awr, aad[55:42]);
    end
    xact(0, 3'b100, 32'hFFFF, 32'h0, rd, er, lat, aad, awr, awd);
    total++;
    if (rd !== 32'h0000_005A || er !== 1'b0) begin
      bad++; $display("FAIL lbu_top got=%h err=%b exp=0000005a", rd, er);
    end
    w0 = wren_cnt0;
    xact(0, 3'b010, 32'hFFFE, 32'h0, rd, er, lat, aad, awr, awd);
    total++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      bad++; $display("FAIL lw_cross err=%b rdata=%h exp err=1 rdata=0", er, rd);
    end
    xact(1, 3'b010, 32'h1_0000, 32'hDEAD_BEEF, rd, er, lat, aad, awr, awd);
    total++;
    if (er !== 1'b1 || wren_cnt0 != w0) begin
      bad++; $display("FAIL sw_out err=%b pulses=%0d exp err=1 pulses=0", er, wren_cnt0 - w0);
    end
  endtask

  task automatic test_illegal_stall();
    int w0;
    xact(0, 3'b011, 32'h10, 32'h0, rd, er, lat, aad, awr, awd);
    total++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      bad++; $display("FAIL ld_f3_011 err=%b rdata=%h exp err=1 rdata=0", er, rd);
    end
    w0 = wren_cnt0;
    xact(1, 3'b100, 32'h10, 32'h0000_0077, rd, er, lat, aad, awr, awd);
    total++;
    if (er !== 1'b1 || wren_cnt0 != w0) begin
      bad++; $display("FAIL st_f3_100 err=%b pulses=%0d exp err=1 pulses=0", er, wren_cnt0 - w0);
    end
    rsp_ready0 = 0;
    @(negedge clk);
    req_valid0 = 1; req_we0 = 0; req_f30 = 3'b100; req_addr0 = 32'h13;
    @(posedge clk); #1;
    req_valid0 = 0;
    @(posedge clk); #1;
    for (int c = 0; c < 5; c++) begin
      total++;
      if (rsp_valid0 !== 1'b1 || rsp_rdata0 !== 32'h80 || rsp_err0 !== 1'b0 || req_ready0 !== 1'b0) begin
        bad++; $display("FAIL stall_hold c=%0d valid=%b rdata=%h err=%b ready=%b exp 1/80/0/0",
                        c, rsp_valid0, rsp_rdata0, rsp_err0, req_ready0);
      end
      @(posedge clk); #1;
    end
    rsp_ready0 = 1;
    @(posedge clk); #1;
    total++;
    if (rsp_valid0 !== 1'b0 || req_ready0 !== 1'b1) begin
      bad++; $display("FAIL stall_release valid=%b ready=%b exp 0/1", rsp_valid0, req_ready0);
    end
  endtask

  task automatic test_reset_mid_access();
    xact(1, 3'b010, 32'h20, 32'h0102_0304, rd, er, lat, aad, awr, awd);
    @(negedge clk);
    req_valid0 = 1; req_we0 = 1; req_f30 = 3'b010; req_addr0 = 32'h20; req_wdata0 = 32'h5566_7788;
    @(posedge clk); #1;
    req_valid0 = 0;
    total++;
    if (bank_wren0 !== 4'hF) begin
      bad++; $display("FAIL abort_pre wren=%b exp=1111", bank_wren0);
    end
    #2 rst = 1;
    #1;
    total++;
    if (bank_wren0 !== 4'h0 || req_ready0 !== 1'b1 || rsp_valid0 !== 1'b0) begin
      bad++; $display("FAIL abort_now wren=%b ready=%b valid=%b exp 0000/1/0", bank_wren0, req_ready0, rsp_valid0);
    end
    @(negedge clk); rst = 0;
    xact(0, 3'b010, 32'h20, 32'h0, rd, er, lat, aad, awr, awd);
    total++;
    if (rd !== 32'h0102_0304 || er !== 1'b0) begin
      bad++; $display("FAIL abort_old_data got=%h err=%b exp=01020304", rd, er);
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_misalign();
    test_range();
    test_illegal_stall();
    test_reset_mid_access();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
